// File: rtl/ydm_stage.sv
// ydm_stage: data-memory (MEM) stage that follows yEX in the RISC-V datapath.
//
// Takes the EX result as the byte address and rd2 as the store data. Performs
// byte, half or word loads and stores on an internal little-endian word RAM
// after a fixed access latency. Non-memory instructions pass the ALU result
// through to write-back with the same latency.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit RAM words (power of 2, at least 2)
//   LAT         - cycles from request accept to response (1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  stage can accept a request (IDLE only)
//   mem_read   in   load instruction
//   mem_write  in   store instruction
//   funct3     in   access size/sign (ins[14:12])
//   addr       in   byte address, or ALU value to pass through
//   wdata      in   store data
//   rsp_valid  out  one-cycle response pulse
//   wb_data    out  write-back value
//   err        out  illegal access, qualified by rsp_valid
//
// Build option:
//   YDM_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses raise
//   err instead of being force-aligned.

module ydm_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LAT         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        finish;

    // Request captured at accept
    logic        rd_q, wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;

    // Registered response
    logic [31:0] wb_q, wb_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] rword;
    logic [31:0] wword;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;
    logic        bad_f3;
    logic        misalign;
    logic        we;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign wb_data   = wb_q;
    assign err       = err_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    assign idx   = addr_q[AW+1:2];
    assign rword = mem[idx];
    assign ld_b  = rword[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h  = addr_q[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        bad_f3 = 1'b0;
        if (rd_q) begin
            bad_f3 = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11);
        end else if (wr_q) begin
            bad_f3 = (f3_q >= 3'b011);
        end

        misalign = 1'b0;
`ifdef YDM_MISALIGN_TRAP_EN
        if (rd_q || wr_q) begin
            case (f3_q[1:0])
                2'b01:   misalign = addr_q[0];
                2'b10:   misalign = (addr_q[1:0] != 2'b00);
                default: misalign = 1'b0;
            endcase
        end
`endif

        err_d = (rd_q && wr_q) || bad_f3 || misalign;

        case (f3_q)
            3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b010:  ld_val = rword;
            3'b100:  ld_val = {24'd0, ld_b};
            3'b101:  ld_val = {16'd0, ld_h};
            default: ld_val = '0;
        endcase

        if (err_d) begin
            wb_d = '0;
        end else if (rd_q) begin
            wb_d = ld_val;
        end else if (wr_q) begin
            wb_d = '0;
        end else begin
            wb_d = addr_q;
        end

        // Read-modify-write merge; half/word lanes ignore the low address
        // bits, which gives force-alignment when trapping is disabled.
        wword = rword;
        case (f3_q[1:0])
            2'b00: wword[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) wword[31:16] = wdata_q[15:0];
                else           wword[15:0]  = wdata_q[15:0];
            end
            default: wword = wdata_q;
        endcase
    end

    // err_q already holds this request's verdict while in RESP
    assign we = (state_q == ST_RESP) && wr_q && !err_q;

    // ---------------- Registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (finish) begin
                wb_q  <= wb_d;
                err_q <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // RAM is never reset; a reset in RESP suppresses the commit
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[idx] <= wword;
        end
    end

endmodule

// File: tb/tb_ydm_stage.sv
// Self-checking bench for ydm_stage: directed scenarios followed by random
// traffic, checked against a byte-array reference model.

module tb_ydm_stage;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned LAT    = 2;
    localparam int unsigned NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0] rmem [NBYTES];

    always #5 clk = ~clk;

    ydm_stage #(
        .DEPTH_WORDS(DEPTH),
        .LAT        (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rsp_valid(rsp_valid),
        .wb_data  (wb_data),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, natural alignment by size.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] ewb, output logic eerr);
        int unsigned off, nb, base;
        logic [31:0] v;
        logic legal;
        ewb  = 32'd0;
        eerr = 1'b0;
        off  = a % NBYTES;
        nb   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        if (!rd && !wr) begin
            ewb = a;
            return;
        end
        if (rd && wr)  legal = 1'b0;
        else if (rd)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else           legal = (f3 <= 3'd2);
`ifdef YDM_MISALIGN_TRAP_EN
        if (legal && (off % nb) != 0) legal = 1'b0;
`endif
        if (!legal) begin
            eerr = 1'b1;
            return;
        end
        base = off - (off % nb);
        if (rd) begin
            v = 32'd0;
            for (int unsigned i = 0; i < nb; i++)
                v = v | ({24'd0, rmem[base + i]} << (8 * i));
            if (!f3[2] && nb < 4 && v[8 * nb - 1])
                v = v | (32'hFFFF_FFFF << (8 * nb));
            ewb = v;
        end else begin
            for (int unsigned i = 0; i < nb; i++)
                rmem[base + i] = 8'(wd >> (8 * i));
        end
    endtask

    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] ewb;
        logic        eerr;
        int          seen;
        model(rd, wr, f3, a, wd, ewb, eerr);
        @(negedge clk);
        chk({tag, " ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the stage must ignore them
        req_valid = 1'b0;
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        seen = -1;
        for (int k = 0; k <= int'(LAT) + 4; k++) begin
            @(negedge clk);
            if (k == 0) chk({tag, " ready_busy"}, {31'd0, req_ready}, 32'd0);
            if (rsp_valid === 1'b1) begin
                seen = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(seen), 32'(LAT));
        if (seen >= 0) begin
            chk({tag, " wb_data"}, wb_data, ewb);
            chk({tag, " err"}, {31'd0, err}, {31'd0, eerr});
            @(negedge clk);
            chk({tag, " pulse"}, {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        rd, wr;
        int unsigned sel;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Fill RAM so every later load has known contents
        for (int unsigned w = 0; w < DEPTH; w++)
            xact(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, "init sw");

        // Basic store/load
        xact(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, "sw 40");
        xact(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw 40");

        // Byte lanes and extensions
        xact(1'b0, 1'b1, 3'b000, 32'h41, 32'h0000_0080, "sb 41");
        xact(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw 40 merged");
        xact(1'b1, 1'b0, 3'b000, 32'h41, 32'h0, "lb 41");
        xact(1'b1, 1'b0, 3'b100, 32'h41, 32'h0, "lbu 41");
        xact(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, "lh 42");
        xact(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, "lhu 42");
        xact(1'b0, 1'b1, 3'b001, 32'h46, 32'hAAAA_8123, "sh 46");
        xact(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, "lw 44");

        // Pass-through leaves RAM alone
        xact(1'b0, 1'b0, 3'b010, 32'h28, 32'hFFFF_FFFF, "pass 28");
        xact(1'b1, 1'b0, 3'b010, 32'h28, 32'h0, "lw 28");

        // Errors
        xact(1'b1, 1'b1, 3'b010, 32'h40, 32'h1111_1111, "rd+wr");
        xact(1'b0, 1'b1, 3'b011, 32'h40, 32'h2222_2222, "store f3 011");
        xact(1'b1, 1'b0, 3'b110, 32'h40, 32'h0, "load f3 110");
        xact(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw 40 after errs");

        // Address wrap
        xact(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, "sw 400 wrap");
        xact(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, "lw 0 wrap");

        // Reset while BUSY drops the store
        @(negedge clk);
        chk("midrst ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h10;
        wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst ready after", {31'd0, req_ready}, 32'd1);
        chk("midrst wb_data", wb_data, 32'd0);
        chk("midrst err", {31'd0, err}, 32'd0);
        for (int k = 0; k < int'(LAT) + 3; k++) begin
            chk("midrst no rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        xact(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw 10 old");

        // Misaligned word load
        xact(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, "sw 40 again");
        xact(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, "lw 42 misalign");
        xact(1'b0, 1'b1, 3'b001, 32'h43, 32'h0000_5A5A, "sh 43 misalign");
        xact(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw 40 post misalign");

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel < 4) || (sel == 9);
            wr  = (sel >= 4 && sel < 7) || (sel == 9);
            a   = $urandom;
            if ($urandom_range(0, 1) == 0) a[9:0] = 10'($urandom_range(0, 127));
            xact(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
